// File: rtl/vt_parser_pkg.sv
// Shared types and byte constants for the VT sequence parser.
// UTF8_CONT exists only when VT_PARSER_UTF8_EN is defined.
package vt_parser_pkg;

  typedef enum logic [1:0] {
    PRINT = 2'd0,
    C0    = 2'd1,
    ESC   = 2'd2,
    CSI   = 2'd3
  } CmdKind_t;

`ifdef VT_PARSER_UTF8_EN
  typedef enum logic [2:0] {
    GROUND, ESCAPE, CSI_ENTRY, CSI_PARAM, CSI_INTER, CSI_IGNORE, UTF8_CONT
  } ParserState_t;
`else
  typedef enum logic [2:0] {
    GROUND, ESCAPE, CSI_ENTRY, CSI_PARAM, CSI_INTER, CSI_IGNORE
  } ParserState_t;
`endif

  localparam logic [7:0]  CH_ESC         = 8'h1B;
  localparam logic [7:0]  CH_CAN         = 8'h18;
  localparam logic [7:0]  CH_SUB         = 8'h1A;
  localparam logic [7:0]  CH_DEL         = 8'h7F;
  localparam logic [20:0] CP_REPLACEMENT = 21'h00FFFD;

  function automatic logic isFinal(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vt_param_accum.sv
// Saturating decimal accumulator for one CSI parameter field.
// Result is registered; clear takes priority over a digit in the same cycle.
module vt_param_accum #(
  parameter int PARAM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               digitEn,
  input  logic [3:0]         digit,
  output logic [PARAM_W-1:0] value,
  output logic               hasDigit,
  output logic               saturated
);

  localparam logic [PARAM_W+3:0] MAX_VAL = {4'b0, {PARAM_W{1'b1}}};

  logic [PARAM_W+3:0] product;

  // value*10 + digit never exceeds 16*2^PARAM_W, so four guard bits suffice
  always_comb begin
    product = ({4'b0, value} << 3) + ({4'b0, value} << 1) + {{PARAM_W{1'b0}}, digit};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value     <= '0;
      hasDigit  <= 1'b0;
      saturated <= 1'b0;
    end else if (digitEn) begin
      hasDigit <= 1'b1;
      if (saturated || (product > MAX_VAL)) begin
        value     <= '1;
        saturated <= 1'b1;
      end else begin
        value <= product[PARAM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vt_sequence_parser.sv
// VT100/ANSI byte-stream parser: one byte per cycle, command registered the cycle after; stalls input while a command waits.
// Define VT_PARSER_UTF8_EN to decode UTF-8 into codepoints instead of passing high bytes through.
module vt_sequence_parser
  import vt_parser_pkg::*;
#(
  parameter int MAX_PARAMS = 16,
  parameter int PARAM_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [1:0]                      cmd_kind,
  output logic [20:0]                     cmd_code,
  output logic                            cmd_private,
  output logic [7:0]                      cmd_inter,
  output logic [$clog2(MAX_PARAMS+1)-1:0] cmd_nparams,
  output logic [MAX_PARAMS*PARAM_W-1:0]   cmd_params,
  output logic [MAX_PARAMS-1:0]           cmd_defmask,
  output logic                            cmd_overflow
);

  localparam int CNT_W = $clog2(MAX_PARAMS+1);

  typedef logic [MAX_PARAMS-1:0][PARAM_W-1:0] ParamArr_t;

  ParserState_t state, nState;
  ParamArr_t params, nParams;
  logic [MAX_PARAMS-1:0] defmask, nDefmask;
  logic [CNT_W-1:0] fieldCnt, nFieldCnt;
  logic anyParam, nAnyParam, seqOvf, nSeqOvf, privFlag, nPrivFlag;
  logic [7:0] inter, nInter;

  logic cmdValid;
  CmdKind_t cmdKind;
  logic [20:0] cmdCode;
  logic cmdPriv, cmdOvf;
  logic [7:0] cmdInter;
  logic [CNT_W-1:0] cmdNparams;
  ParamArr_t cmdParams;
  logic [MAX_PARAMS-1:0] cmdDefmask;

  logic emitVld, emitPriv, emitOvf;
  CmdKind_t emitKind;
  logic [20:0] emitCode;
  logic [7:0] emitInter;
  logic [CNT_W-1:0] emitNparams;
  ParamArr_t emitParams;
  logic [MAX_PARAMS-1:0] emitDefmask;

  logic accClear, accDigit, accHasDigit, accSat;
  logic [PARAM_W-1:0] accValue;
  logic doClose, emitCsi, clearSeq;

  logic slotFree, take;
  logic [7:0] byteIn;

  assign slotFree = !cmdValid || cmd_ready;

`ifdef VT_PARSER_UTF8_EN
  logic [14:0] utfCp, nUtfCp;
  logic [1:0] utfLeft, nUtfLeft;
  logic replayVld, nReplayVld;
  logic [7:0] replayByte, nReplayByte;

  // A byte rejected inside a UTF-8 sequence is replayed from GROUND before new input
  assign byteIn   = replayVld ? replayByte : in_data;
  assign take     = slotFree && (replayVld || in_valid);
  assign in_ready = slotFree && !replayVld;
`else
  assign byteIn   = in_data;
  assign take     = slotFree && in_valid;
  assign in_ready = slotFree;
`endif

  vt_param_accum #(.PARAM_W(PARAM_W)) uAccum (
    .clk      (clk),
    .rst      (rst),
    .clear    (accClear),
    .digitEn  (accDigit),
    .digit    (byteIn[3:0]),
    .value    (accValue),
    .hasDigit (accHasDigit),
    .saturated(accSat)
  );

  always_comb begin
    nState      = state;
    nParams     = params;
    nDefmask    = defmask;
    nFieldCnt   = fieldCnt;
    nAnyParam   = anyParam;
    nSeqOvf     = seqOvf;
    nPrivFlag   = privFlag;
    nInter      = inter;
    emitVld     = 1'b0;
    emitKind    = PRINT;
    emitCode    = '0;
    emitPriv    = 1'b0;
    emitInter   = '0;
    emitNparams = '0;
    emitParams  = '0;
    emitDefmask = '0;
    emitOvf     = 1'b0;
    accClear    = 1'b0;
    accDigit    = 1'b0;
    doClose     = 1'b0;
    emitCsi     = 1'b0;
    clearSeq    = 1'b0;
`ifdef VT_PARSER_UTF8_EN
    nUtfCp      = utfCp;
    nUtfLeft    = utfLeft;
    nReplayVld  = take ? 1'b0 : replayVld;
    nReplayByte = replayByte;
`endif

    if (take) begin
`ifdef VT_PARSER_UTF8_EN
      if (state == UTF8_CONT) begin
        if (byteIn[7:6] == 2'b10) begin
          nUtfCp   = {utfCp[8:0], byteIn[5:0]};
          nUtfLeft = utfLeft - 2'd1;
          if (utfLeft == 2'd1) begin
            emitVld  = 1'b1;
            emitCode = {utfCp, byteIn[5:0]};
            nState   = GROUND;
          end
        end else begin
          emitVld     = 1'b1;
          emitCode    = CP_REPLACEMENT;
          nState      = GROUND;
          nReplayVld  = 1'b1;
          nReplayByte = byteIn;
        end
      end else
`endif
      if ((byteIn == CH_CAN) || (byteIn == CH_SUB)) begin
        nState   = GROUND;
        clearSeq = 1'b1;
      end else if (byteIn == CH_ESC) begin
        nState   = ESCAPE;
        clearSeq = 1'b1;
      end else if (byteIn == CH_DEL) begin
        nState = state;
      end else if (byteIn < 8'h20) begin
        // Embedded controls execute immediately and leave the sequence intact
        emitVld  = 1'b1;
        emitKind = C0;
        emitCode = {13'b0, byteIn};
      end else begin
        case (state)
          GROUND: begin
            if (byteIn < 8'h80) begin
              emitVld  = 1'b1;
              emitCode = {13'b0, byteIn};
            end else begin
`ifdef VT_PARSER_UTF8_EN
              if ((byteIn >= 8'hC2) && (byteIn <= 8'hDF)) begin
                nUtfCp   = {10'b0, byteIn[4:0]};
                nUtfLeft = 2'd1;
                nState   = UTF8_CONT;
              end else if ((byteIn >= 8'hE0) && (byteIn <= 8'hEF)) begin
                nUtfCp   = {11'b0, byteIn[3:0]};
                nUtfLeft = 2'd2;
                nState   = UTF8_CONT;
              end else if ((byteIn >= 8'hF0) && (byteIn <= 8'hF4)) begin
                nUtfCp   = {12'b0, byteIn[2:0]};
                nUtfLeft = 2'd3;
                nState   = UTF8_CONT;
              end else begin
                emitVld  = 1'b1;
                emitCode = CP_REPLACEMENT;
              end
`else
              emitVld  = 1'b1;
              emitCode = {13'b0, byteIn};
`endif
            end
          end
          ESCAPE: begin
            if (byteIn == 8'h5B) begin
              nState = CSI_ENTRY;
              nInter = '0;
            end else if (byteIn < 8'h30) begin
              nInter = byteIn;
            end else if (byteIn < 8'h7F) begin
              emitVld   = 1'b1;
              emitKind  = ESC;
              emitCode  = {13'b0, byteIn};
              emitInter = inter;
              nState    = GROUND;
              clearSeq  = 1'b1;
            end
          end
          CSI_ENTRY, CSI_PARAM: begin
            if (byteIn inside {[8'h30:8'h39]}) begin
              accDigit  = 1'b1;
              nAnyParam = 1'b1;
              nState    = CSI_PARAM;
            end else if (byteIn == 8'h3B) begin
              doClose   = 1'b1;
              nAnyParam = 1'b1;
              nState    = CSI_PARAM;
            end else if (byteIn inside {[8'h3C:8'h3F]}) begin
              if (state == CSI_ENTRY) begin
                nPrivFlag = 1'b1;
                nState    = CSI_PARAM;
              end else begin
                nState = CSI_IGNORE;
              end
            end else if (byteIn == 8'h3A) begin
              nState = CSI_IGNORE;
            end else if (byteIn < 8'h30) begin
              nInter = byteIn;
              nState = CSI_INTER;
            end else if (isFinal(byteIn)) begin
              emitCsi = 1'b1;
            end
          end
          CSI_INTER: begin
            if (byteIn < 8'h30) begin
              nInter = byteIn;
            end else if (byteIn < 8'h40) begin
              nState = CSI_IGNORE;
            end else if (isFinal(byteIn)) begin
              emitCsi = 1'b1;
            end
          end
          CSI_IGNORE: begin
            if (isFinal(byteIn)) begin
              nState   = GROUND;
              clearSeq = 1'b1;
            end
          end
          default: nState = GROUND;
        endcase
      end
    end

    // The final byte closes the last field only if the sequence had parameter characters
    if (emitCsi && anyParam) doClose = 1'b1;

    if (doClose) begin
      for (int i = 0; i < MAX_PARAMS; i++) begin
        if (fieldCnt == CNT_W'(i)) begin
          nParams[i]  = accHasDigit ? accValue : '0;
          nDefmask[i] = !accHasDigit;
        end
      end
      if (fieldCnt < CNT_W'(MAX_PARAMS)) nFieldCnt = fieldCnt + 1'b1;
      else                               nSeqOvf   = 1'b1;
      if (accSat) nSeqOvf = 1'b1;
      accClear = 1'b1;
    end

    if (emitCsi) begin
      emitVld     = 1'b1;
      emitKind    = CSI;
      emitCode    = {13'b0, byteIn};
      emitPriv    = privFlag;
      emitInter   = inter;
      emitNparams = anyParam ? nFieldCnt : '0;
      emitParams  = nParams;
      emitDefmask = nDefmask;
      emitOvf     = nSeqOvf;
      nState      = GROUND;
      clearSeq    = 1'b1;
    end

    if (clearSeq) begin
      nParams   = '0;
      nDefmask  = '0;
      nFieldCnt = '0;
      nAnyParam = 1'b0;
      nSeqOvf   = 1'b0;
      nPrivFlag = 1'b0;
      nInter    = '0;
      accClear  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GROUND;
      params     <= '0;
      defmask    <= '0;
      fieldCnt   <= '0;
      anyParam   <= 1'b0;
      seqOvf     <= 1'b0;
      privFlag   <= 1'b0;
      inter      <= '0;
      cmdValid   <= 1'b0;
      cmdKind    <= PRINT;
      cmdCode    <= '0;
      cmdPriv    <= 1'b0;
      cmdInter   <= '0;
      cmdNparams <= '0;
      cmdParams  <= '0;
      cmdDefmask <= '0;
      cmdOvf     <= 1'b0;
    end else begin
      state    <= nState;
      params   <= nParams;
      defmask  <= nDefmask;
      fieldCnt <= nFieldCnt;
      anyParam <= nAnyParam;
      seqOvf   <= nSeqOvf;
      privFlag <= nPrivFlag;
      inter    <= nInter;
      if (emitVld) begin
        cmdValid   <= 1'b1;
        cmdKind    <= emitKind;
        cmdCode    <= emitCode;
        cmdPriv    <= emitPriv;
        cmdInter   <= emitInter;
        cmdNparams <= emitNparams;
        cmdParams  <= emitParams;
        cmdDefmask <= emitDefmask;
        cmdOvf     <= emitOvf;
      end else if (cmd_ready) begin
        cmdValid <= 1'b0;
      end
    end
  end

`ifdef VT_PARSER_UTF8_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      utfCp      <= '0;
      utfLeft    <= '0;
      replayVld  <= 1'b0;
      replayByte <= '0;
    end else begin
      utfCp      <= nUtfCp;
      utfLeft    <= nUtfLeft;
      replayVld  <= nReplayVld;
      replayByte <= nReplayByte;
    end
  end
`endif

  assign cmd_valid    = cmdValid;
  assign cmd_kind     = cmdKind;
  assign cmd_code     = cmdCode;
  assign cmd_private  = cmdPriv;
  assign cmd_inter    = cmdInter;
  assign cmd_nparams  = cmdNparams;
  assign cmd_params   = cmdParams;
  assign cmd_defmask  = cmdDefmask;
  assign cmd_overflow = cmdOvf;

endmodule

// File: tb/tb_vt_sequence_parser.sv
// Directed bench for vt_sequence_parser: byte strings in, commands captured at the handshake and compared.
module tb_vt_sequence_parser;
  import vt_parser_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_kind;
  logic [20:0]  cmd_code;
  logic         cmd_private;
  logic [7:0]   cmd_inter;
  logic [4:0]   cmd_nparams;
  logic [127:0] cmd_params;
  logic [15:0]  cmd_defmask;
  logic         cmd_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]   kind;
    logic [20:0]  code;
    logic         priv;
    logic [7:0]   inter;
    logic [4:0]   np;
    logic [127:0] params;
    logic [15:0]  dm;
    logic         ovf;
  } cmd_t;

  cmd_t q[$];

  vt_sequence_parser dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_kind    (cmd_kind),
    .cmd_code    (cmd_code),
    .cmd_private (cmd_private),
    .cmd_inter   (cmd_inter),
    .cmd_nparams (cmd_nparams),
    .cmd_params  (cmd_params),
    .cmd_defmask (cmd_defmask),
    .cmd_overflow(cmd_overflow)
  );

  always #5 clk = ~clk;

  // Handshake happens at the next rising edge; inputs only change after rising edges
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready)
      q.push_back('{cmd_kind, cmd_code, cmd_private, cmd_inter, cmd_nparams,
                    cmd_params, cmd_defmask, cmd_overflow});
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("in_ready_for_%02h", b), in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic checkCmd(input string tag, input logic [1:0] kind, input logic [20:0] code,
                          input logic priv, input logic [7:0] inter, input logic [4:0] np,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input logic [15:0] dm, input logic ovf);
    cmd_t got;
    for (int n = 0; n < 20 && q.size() == 0; n++) @(negedge clk);
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL %s no command got=0 exp=1", tag);
    end
    if (q.size() != 0) begin
      got = q.pop_front();
      chk({tag, ".kind"},    got.kind,   kind);
      chk({tag, ".code"},    got.code,   code);
      chk({tag, ".private"}, got.priv,   priv);
      chk({tag, ".inter"},   got.inter,  inter);
      chk({tag, ".nparams"}, got.np,     np);
      chk({tag, ".params"},  got.params, {112'b0, p1, p0});
      chk({tag, ".defmask"}, got.dm,     dm);
      chk({tag, ".ovf"},     got.ovf,    ovf);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cmd_valid", cmd_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.cmd_code", cmd_code, 0);
    chk("rst.cmd_params", cmd_params, 0);
    chk("rst.cmd_defmask", cmd_defmask, 0);
    chk("rst.cmd_overflow", cmd_overflow, 0);
    rst = 1'b0;

    sendByte(8'h1B); sendStr("[12;5H");
    checkCmd("cup", CSI, 21'h48, 0, 8'h00, 5'd2, 8'd12, 8'd5, 16'h0000, 0);

    sendByte(8'h1B); sendStr("[;7m");
    checkCmd("sgr_empty", CSI, 21'h6D, 0, 8'h00, 5'd2, 8'd0, 8'd7, 16'h0001, 0);

    sendByte(8'h1B); sendStr("[999m");
    checkCmd("saturate", CSI, 21'h6D, 0, 8'h00, 5'd1, 8'd255, 8'd0, 16'h0000, 1);

    sendByte(8'h1B); sendStr("[?25l");
    checkCmd("private", CSI, 21'h6C, 1, 8'h00, 5'd1, 8'd25, 8'd0, 16'h0000, 0);

    sendByte(8'h1B); sendStr("[m");
    checkCmd("no_params", CSI, 21'h6D, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);

    sendByte(8'h1B); sendStr("[1"); sendByte(CH_CAN); sendStr("A");
    checkCmd("can_abort", PRINT, 21'h41, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);

    sendByte(8'h1B); sendStr("[");
    repeat (16) sendStr(";");
    sendStr("m");
    checkCmd("too_many", CSI, 21'h6D, 0, 8'h00, 5'd16, 8'd0, 8'd0, 16'hFFFF, 1);

    sendByte(8'h1B); sendStr("[2 q");
    checkCmd("inter", CSI, 21'h71, 0, 8'h20, 5'd1, 8'd2, 8'd0, 16'h0000, 0);

    sendByte(8'h1B); sendStr("[ 1qC");
    checkCmd("ignore", PRINT, 21'h43, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);

    sendStr("Z"); sendByte(8'h07); sendByte(8'h1B); sendStr("7"); sendByte(CH_DEL); sendStr("B");
    checkCmd("print_z", PRINT, 21'h5A, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    checkCmd("bell", C0, 21'h07, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    checkCmd("esc7", ESC, 21'h37, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    checkCmd("del_skip", PRINT, 21'h42, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);

    // Consumer stalls on the embedded CR; the '4' must wait and not be lost
    cmd_ready = 1'b0;
    sendByte(8'h1B); sendStr("[3"); sendByte(8'h0D);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h34;
    for (int i = 0; i < 5; i++) begin
      chk("stall.in_ready", in_ready, 0);
      chk("stall.cmd_valid", cmd_valid, 1);
      chk("stall.cmd_kind", cmd_kind, C0);
      chk("stall.cmd_code", cmd_code, 21'h0D);
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sendStr("A");
    checkCmd("stall_cr", C0, 21'h0D, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    checkCmd("stall_csi", CSI, 21'h41, 0, 8'h00, 5'd1, 8'd34, 8'd0, 16'h0000, 0);

`ifdef VT_PARSER_UTF8_EN
    sendByte(8'hE4); sendByte(8'hB8); sendByte(8'hAD);
    checkCmd("utf8_ok", PRINT, 21'h4E2D, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    sendByte(8'hE4); sendByte(8'h41);
    checkCmd("utf8_bad", PRINT, 21'hFFFD, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
    checkCmd("utf8_replay", PRINT, 21'h41, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
`else
    sendByte(8'hE4);
    checkCmd("high_byte", PRINT, 21'hE4, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);
`endif

    sendByte(8'h1B); sendStr("[5");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst.cmd_valid", cmd_valid, 0);
    chk("midrst.cmd_code", cmd_code, 0);
    chk("midrst.cmd_nparams", cmd_nparams, 0);
    chk("midrst.in_ready", in_ready, 1);
    sendStr("m");
    checkCmd("after_rst", PRINT, 21'h6D, 0, 8'h00, 5'd0, 8'd0, 8'd0, 16'h0000, 0);

    repeat (4) @(negedge clk);
    chk("no_extra_cmds", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
